// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types for the ctrl_seq instruction sequencer.
//   state_t        - sequencer state encoding (visible on state_o)
//   branch_t       - PC / control-flow behaviour of an opcode
//   strobes_t      - the complete set of datapath strobes, bundled
//   decode_entry_t - per-opcode control word
//   decode()       - opcode -> control word lookup
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH_COMM = 3'd0,
        FETCH_REG  = 3'd1,
        FETCH_MEM  = 3'd2,
        EXECUTE    = 3'd3,
        HALT       = 3'd4,
        FAULT      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_ALWAYS = 3'd1,
        BR_SF     = 3'd2,   // legacy JS: tests flags[FLAG_SF]
        BR_GF     = 3'd3,   // legacy JG: tests flags[FLAG_GF]
        BR_COND   = 3'd4,   // JCC: tests flags[cond_idx] ^ cond_neg
        BR_HALT   = 3'd5
    } branch_t;

    // Flag masks are carried at a fixed maximum width; ctrl_seq keeps its
    // flag register at this width too, with bits >= NFLAGS tied to zero.
    localparam int MAX_FLAGS       = 16;
    localparam int MAX_FLAG_IDX_W  = 4;
    localparam int FLAG_SF         = 0;
    localparam int FLAG_GF         = 1;

    localparam logic [MAX_FLAGS-1:0] FLAG_MASK_NONE = '0;
    localparam logic [MAX_FLAGS-1:0] FLAG_MASK_SG   = 16'h0003;
    localparam logic [MAX_FLAGS-1:0] FLAG_MASK_ALL  = '1;

    // Opcodes, zero-extended to 32 bits so any OPW up to 31 compares cleanly.
    localparam logic [31:0] OP_LOAD  = 32'h00;
    localparam logic [31:0] OP_STORE = 32'h01;
    localparam logic [31:0] OP_PUSH  = 32'h02;
    localparam logic [31:0] OP_POP   = 32'h03;
    localparam logic [31:0] OP_MOVI  = 32'h04;
    localparam logic [31:0] OP_ADD   = 32'h05;
    localparam logic [31:0] OP_CMP   = 32'h06;
    localparam logic [31:0] OP_JMP   = 32'h0E;
    localparam logic [31:0] OP_JS    = 32'h0F;
    localparam logic [31:0] OP_JG    = 32'h10;
    localparam logic [31:0] OP_JCC   = 32'h13;
    localparam logic [31:0] OP_HALT  = 32'h1F;

    typedef struct packed {
        logic resultSrc;
        logic memWE;
        logic mem1RE;
        logic mem2RE;
        logic mem3RE;
        logic mem4RE;
        logic regWE;
        logic reg1RE;
        logic reg2RE;
        logic reg3RE;
        logic pcEn;
        logic op1RE;
        logic op2RE;
        logic RiRE;
        logic pcSrc;
        logic instrWrite;
        logic push;
        logic pop;
    } strobes_t;

    typedef struct packed {
        logic                 reg1RE;
        logic                 reg2RE;
        logic                 reg3RE;
        logic                 RiRE;
        logic                 op1_src;    // latch operand 1 from the register file
        logic                 op2_src;    // latch operand 2 from the register file
        logic                 mem_rd;     // operand fetch from memory in FETCH_MEM
        logic                 resultSrc;
        logic                 regWE;
        logic                 memWE;
        logic                 push;
        logic                 pop;
        branch_t              branch;
        logic [MAX_FLAGS-1:0] flag_mask;
    } decode_entry_t;

    // Opcodes not listed return an all-zero entry: no strobes, no flag change.
    function automatic decode_entry_t decode(input logic [31:0] opc);
        decode_entry_t e;
        e = '0;
        case (opc)
            OP_LOAD: begin
                e.reg1RE = 1'b1; e.op2_src = 1'b1; e.mem_rd = 1'b1;
                e.resultSrc = 1'b1; e.regWE = 1'b1;
            end
            OP_STORE: begin
                e.reg1RE = 1'b1; e.reg2RE = 1'b1; e.op1_src = 1'b1;
                e.op2_src = 1'b1; e.memWE = 1'b1;
            end
            OP_PUSH: begin
                e.reg1RE = 1'b1; e.op1_src = 1'b1; e.push = 1'b1;
            end
            OP_POP: begin
                e.pop = 1'b1; e.regWE = 1'b1; e.resultSrc = 1'b1;
            end
            OP_MOVI: begin
                e.RiRE = 1'b1; e.regWE = 1'b1;
            end
            OP_ADD: begin
                e.reg1RE = 1'b1; e.reg2RE = 1'b1; e.op1_src = 1'b1;
                e.op2_src = 1'b1; e.regWE = 1'b1; e.flag_mask = FLAG_MASK_SG;
            end
            OP_CMP: begin
                e.reg1RE = 1'b1; e.reg2RE = 1'b1; e.op1_src = 1'b1;
                e.op2_src = 1'b1; e.flag_mask = FLAG_MASK_ALL;
            end
            OP_JMP:  e.branch = BR_ALWAYS;
            OP_JS:   e.branch = BR_SF;
            OP_JG:   e.branch = BR_GF;
            OP_JCC:  e.branch = BR_COND;
            OP_HALT: e.branch = BR_HALT;
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> control word lookup.
//   opcode - current instruction opcode (OPW bits)
//   entry  - decoded control word for that opcode
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output decode_entry_t  entry
);

    logic [31:0] opc_ext;

    always_comb begin
        opc_ext            = '0;
        opc_ext[OPW-1:0]   = opcode;
        entry              = decode(opc_ext);
    end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle instruction sequencer.
// Ports:
//   clk, rst                 - clock; synchronous active-low reset
//   mem_ready                - memory access completes this cycle
//   opcode                   - current instruction (stable FETCH_REG..next FETCH_COMM)
//   cond_idx, cond_neg       - JCC flag selector and inversion
//   flags_in                 - datapath flag results, sampled on EXECUTE exit
//   resultSrc .. pop         - combinational datapath strobes
//   flags                    - registered flag state
//   state_o, halted, fault   - state visibility
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int OPW     = 5,
    parameter int NFLAGS  = 4,    // 2..MAX_FLAGS
    parameter int TIMEOUT = 255   // >= 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_ready,
    input  logic [OPW-1:0]            opcode,
    input  logic [$clog2(NFLAGS)-1:0] cond_idx,
    input  logic                      cond_neg,
    input  logic [NFLAGS-1:0]         flags_in,
    output logic                      resultSrc,
    output logic                      memWE,
    output logic                      mem1RE,
    output logic                      mem2RE,
    output logic                      mem3RE,
    output logic                      mem4RE,
    output logic                      regWE,
    output logic                      reg1RE,
    output logic                      reg2RE,
    output logic                      reg3RE,
    output logic                      pcEn,
    output logic                      op1RE,
    output logic                      op2RE,
    output logic                      RiRE,
    output logic                      pcSrc,
    output logic                      instrWrite,
    output logic                      push,
    output logic                      pop,
    output logic [NFLAGS-1:0]         flags,
    output logic [2:0]                state_o,
    output logic                      halted,
    output logic                      fault
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t               state, state_next;
    logic [CNT_W-1:0]     wait_cnt;
    logic [MAX_FLAGS-1:0] flag_q;
    logic [MAX_FLAGS-1:0] flags_in_ext;
    decode_entry_t        entry;
    strobes_t             stb;
    logic                 waiting;
    logic                 timed_out;
    logic                 taken;
    logic                 exec_done;

    ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode (opcode),
        .entry  (entry)
    );

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT));

    always_comb begin
        flags_in_ext             = '0;
        flags_in_ext[NFLAGS-1:0] = flags_in;
    end

    // Branch condition. An out-of-range JCC selector never branches,
    // regardless of cond_neg.
    always_comb begin
        taken = 1'b0;
        case (entry.branch)
            BR_ALWAYS: taken = 1'b1;
            BR_SF:     taken = flag_q[FLAG_SF];
            BR_GF:     taken = flag_q[FLAG_GF];
            BR_COND:   taken = (int'(cond_idx) < NFLAGS) &&
                               (flag_q[MAX_FLAG_IDX_W'(cond_idx)] ^ cond_neg);
            default:   taken = 1'b0;
        endcase
    end

    // NOTE: every signal written here gets a default first so no path
    // through the case statement leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        stb        = '0;
        waiting    = 1'b0;
        case (state)
            FETCH_COMM: begin
                stb.mem1RE = 1'b1;
                stb.mem2RE = 1'b1;
                stb.mem3RE = 1'b1;
                waiting    = 1'b1;
                if (mem_ready) begin
                    stb.instrWrite = 1'b1;
                    stb.pcEn       = 1'b1;
                    state_next     = FETCH_REG;
                end else if (timed_out) begin
                    state_next = FAULT;
                end
            end
            FETCH_REG: begin
                stb.reg1RE = entry.reg1RE;
                stb.reg2RE = entry.reg2RE;
                stb.reg3RE = entry.reg3RE;
                stb.RiRE   = entry.RiRE;
                stb.op1RE  = entry.op1_src;
                stb.op2RE  = entry.op2_src;
                state_next = FETCH_MEM;
            end
            FETCH_MEM: begin
                if (entry.mem_rd) begin
                    stb.mem4RE = 1'b1;
                    stb.op1RE  = 1'b1;
                    waiting    = 1'b1;
                    if (mem_ready)      state_next = EXECUTE;
                    else if (timed_out) state_next = FAULT;
                end else begin
                    state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                stb.resultSrc = entry.resultSrc;
                stb.regWE     = entry.regWE;
                stb.memWE     = entry.memWE;
                stb.push      = entry.push;
                stb.pop       = entry.pop;
                stb.pcEn      = taken;
                stb.pcSrc     = taken;
                if (entry.branch == BR_HALT) begin
                    state_next = HALT;
                end else if (entry.memWE) begin
                    waiting = 1'b1;
                    if (mem_ready)      state_next = FETCH_COMM;
                    else if (timed_out) state_next = FAULT;
                end else begin
                    state_next = FETCH_COMM;
                end
            end
            HALT:    state_next = HALT;
            FAULT:   state_next = FAULT;
            default: state_next = FAULT;
        endcase
        // Reset is sampled synchronously, but the strobes must be quiet for
        // the whole cycle in which it is held low.
        if (!rst) stb = '0;
    end

    assign exec_done = (state == EXECUTE) && (state_next == FETCH_COMM);

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FETCH_COMM;
            wait_cnt <= '0;
            flag_q   <= '0;
        end else begin
            state <= state_next;
            // Any state change clears the counter, which covers entry into
            // each waiting state; inside a wait it saturates at TIMEOUT.
            if (state_next != state)
                wait_cnt <= '0;
            else if (waiting && !mem_ready && !timed_out)
                wait_cnt <= wait_cnt + 1'b1;
            if (exec_done)
                flag_q <= (flag_q & ~entry.flag_mask) | (flags_in_ext & entry.flag_mask);
        end
    end

    assign resultSrc  = stb.resultSrc;
    assign memWE      = stb.memWE;
    assign mem1RE     = stb.mem1RE;
    assign mem2RE     = stb.mem2RE;
    assign mem3RE     = stb.mem3RE;
    assign mem4RE     = stb.mem4RE;
    assign regWE      = stb.regWE;
    assign reg1RE     = stb.reg1RE;
    assign reg2RE     = stb.reg2RE;
    assign reg3RE     = stb.reg3RE;
    assign pcEn       = stb.pcEn;
    assign op1RE      = stb.op1RE;
    assign op2RE      = stb.op2RE;
    assign RiRE       = stb.RiRE;
    assign pcSrc      = stb.pcSrc;
    assign instrWrite = stb.instrWrite;
    assign push       = stb.push;
    assign pop        = stb.pop;

    assign flags   = flag_q[NFLAGS-1:0];
    assign state_o = state;
    assign halted  = (state == HALT);
    assign fault   = (state == FAULT);

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed + randomized instruction-level checks of ctrl_seq.
module tb_ctrl_seq;

    localparam int OPW     = 5;
    localparam int NFLAGS  = 4;
    localparam int TIMEOUT = 4;

    // Bit positions inside the bench's packed strobe vector.
    localparam logic [17:0] B_POP    = 18'd1 << 0;
    localparam logic [17:0] B_PUSH   = 18'd1 << 1;
    localparam logic [17:0] B_IW     = 18'd1 << 2;
    localparam logic [17:0] B_PCSRC  = 18'd1 << 3;
    localparam logic [17:0] B_RI     = 18'd1 << 4;
    localparam logic [17:0] B_OP2    = 18'd1 << 5;
    localparam logic [17:0] B_OP1    = 18'd1 << 6;
    localparam logic [17:0] B_PCEN   = 18'd1 << 7;
    localparam logic [17:0] B_REG3   = 18'd1 << 8;
    localparam logic [17:0] B_REG2   = 18'd1 << 9;
    localparam logic [17:0] B_REG1   = 18'd1 << 10;
    localparam logic [17:0] B_REGWE  = 18'd1 << 11;
    localparam logic [17:0] B_MEM4   = 18'd1 << 12;
    localparam logic [17:0] B_MEM3   = 18'd1 << 13;
    localparam logic [17:0] B_MEM2   = 18'd1 << 14;
    localparam logic [17:0] B_MEM1   = 18'd1 << 15;
    localparam logic [17:0] B_MEMWE  = 18'd1 << 16;
    localparam logic [17:0] B_RES    = 18'd1 << 17;
    localparam logic [17:0] MEM123   = B_MEM1 | B_MEM2 | B_MEM3;

    logic              clk, rst, mem_ready, cond_neg;
    logic [OPW-1:0]    opcode;
    logic [1:0]        cond_idx;
    logic [NFLAGS-1:0] flags_in, flags;
    logic              resultSrc, memWE, mem1RE, mem2RE, mem3RE, mem4RE, regWE;
    logic              reg1RE, reg2RE, reg3RE, pcEn, op1RE, op2RE, RiRE, pcSrc;
    logic              instrWrite, push, pop, halted, fault;
    logic [2:0]        state_o;
    logic [17:0]       stb_vec;

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  mflags;          // reference flag state
    logic        rand_idle;       // randomize mem_ready where it is a don't-care

    ctrl_seq #(.OPW(OPW), .NFLAGS(NFLAGS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .opcode(opcode),
        .cond_idx(cond_idx), .cond_neg(cond_neg), .flags_in(flags_in),
        .resultSrc(resultSrc), .memWE(memWE), .mem1RE(mem1RE), .mem2RE(mem2RE),
        .mem3RE(mem3RE), .mem4RE(mem4RE), .regWE(regWE), .reg1RE(reg1RE),
        .reg2RE(reg2RE), .reg3RE(reg3RE), .pcEn(pcEn), .op1RE(op1RE),
        .op2RE(op2RE), .RiRE(RiRE), .pcSrc(pcSrc), .instrWrite(instrWrite),
        .push(push), .pop(pop), .flags(flags), .state_o(state_o),
        .halted(halted), .fault(fault)
    );

    assign stb_vec = {resultSrc, memWE, mem1RE, mem2RE, mem3RE, mem4RE, regWE,
                      reg1RE, reg2RE, reg3RE, pcEn, op1RE, op2RE, RiRE, pcSrc,
                      instrWrite, push, pop};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction-level description of each opcode's behaviour.
    typedef struct {
        logic [17:0] rd;      // strobes in the register-read cycle
        logic        mem_rd;
        logic [17:0] ex;      // strobes in EXECUTE (branch strobes added separately)
        logic        mem_wr;
        int          br;      // 0 none, 1 always, 2 flag0, 3 flag1, 4 cond
        logic [3:0]  mask;
        logic        halt;
    } op_t;

    function automatic op_t spec_op(input logic [4:0] opc);
        op_t o;
        o.rd = '0; o.mem_rd = 1'b0; o.ex = '0; o.mem_wr = 1'b0;
        o.br = 0; o.mask = 4'b0000; o.halt = 1'b0;
        case (opc)
            5'b00000: begin o.rd = B_REG1 | B_OP2; o.mem_rd = 1'b1; o.ex = B_RES | B_REGWE; end
            5'b00001: begin o.rd = B_REG1 | B_REG2 | B_OP1 | B_OP2; o.ex = B_MEMWE; o.mem_wr = 1'b1; end
            5'b00010: begin o.rd = B_REG1 | B_OP1; o.ex = B_PUSH; end
            5'b00011: begin o.ex = B_POP | B_REGWE | B_RES; end
            5'b00100: begin o.rd = B_RI; o.ex = B_REGWE; end
            5'b00101: begin o.rd = B_REG1 | B_REG2 | B_OP1 | B_OP2; o.ex = B_REGWE; o.mask = 4'b0011; end
            5'b00110: begin o.rd = B_REG1 | B_REG2 | B_OP1 | B_OP2; o.mask = 4'b1111; end
            5'b01110: o.br = 1;
            5'b01111: o.br = 2;
            5'b10000: o.br = 3;
            5'b10011: o.br = 4;
            5'b11111: o.halt = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic branch_taken(input op_t o, input logic [1:0] ci, input logic cn);
        case (o.br)
            1:       return 1'b1;
            2:       return mflags[0];
            3:       return mflags[1];
            4:       return mflags[ci] ^ cn;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven; sample at the falling edge.
    task automatic step(input string tag, input int st, input logic [17:0] stb);
        @(negedge clk);
        check({tag, ".state"},   32'(state_o), 32'(st));
        check({tag, ".strobes"}, 32'(stb_vec), 32'(stb));
        check({tag, ".flags"},   32'(flags),   32'(mflags));
        check({tag, ".halted"},  32'(halted),  32'(st == 4));
        check({tag, ".fault"},   32'(fault),   32'(st == 5));
        @(posedge clk);
        #1;
    endtask

    function automatic logic idle_ready();
        return rand_idle ? 1'($urandom) : 1'b1;
    endfunction

    task automatic do_reset();
        rst       = 1'b0;
        mem_ready = 1'($urandom);
        @(negedge clk);
        check("rst.strobes", 32'(stb_vec), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mflags = 4'b0000;
    endtask

    // Full instruction; fw/mw/ew are not-ready cycles before the ready cycle
    // of the fetch, memory-operand and memory-write waits (all <= TIMEOUT).
    task automatic run_instr(input logic [4:0] opc, input int fw, input int mw,
                             input int ew, input logic [3:0] fin,
                             input logic [1:0] ci, input logic cn);
        op_t         o;
        logic [17:0] exs;
        o        = spec_op(opc);
        opcode   = opc;
        flags_in = fin;
        cond_idx = ci;
        cond_neg = cn;
        for (int i = 0; i < fw; i++) begin mem_ready = 1'b0; step("fetch_wait", 0, MEM123); end
        mem_ready = 1'b1;
        step("fetch", 0, MEM123 | B_IW | B_PCEN);
        mem_ready = idle_ready();
        step("freg", 1, o.rd);
        if (o.mem_rd) begin
            for (int i = 0; i < mw; i++) begin mem_ready = 1'b0; step("fmem_wait", 2, B_MEM4 | B_OP1); end
            mem_ready = 1'b1;
            step("fmem", 2, B_MEM4 | B_OP1);
        end else begin
            mem_ready = idle_ready();
            step("fmem", 2, 18'd0);
        end
        exs = o.ex | (branch_taken(o, ci, cn) ? (B_PCEN | B_PCSRC) : 18'd0);
        if (o.halt) begin
            mem_ready = idle_ready();
            step("exec_halt", 3, 18'd0);
            return;
        end
        if (o.mem_wr) begin
            for (int i = 0; i < ew; i++) begin mem_ready = 1'b0; step("exec_wait", 3, exs); end
            mem_ready = 1'b1;
            step("exec", 3, exs);
        end else begin
            mem_ready = idle_ready();
            step("exec", 3, exs);
        end
        mflags = (mflags & ~o.mask) | (fin & o.mask);
    endtask

    logic [4:0] ops [15] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                             5'b00101, 5'b00110, 5'b01110, 5'b01111, 5'b10000,
                             5'b10011, 5'b00111, 5'b01000, 5'b10101, 5'b11110};

    initial begin
        rst = 1'b0; mem_ready = 1'b0; opcode = '0; cond_idx = '0; cond_neg = 1'b0;
        flags_in = '0; mflags = '0; rand_idle = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // mem_ready tied high, ADD: 0,1,2,3,0 with regWE in EXECUTE.
        run_instr(5'b00101, 0, 0, 0, 4'b0001, 2'd0, 1'b0);
        // Fetch stalled 3 cycles; also checks flags == 0001 throughout.
        run_instr(5'b00100, 3, 0, 0, 4'b1111, 2'd0, 1'b0);

        // JCC on flags == 0100.
        run_instr(5'b00110, 0, 0, 0, 4'b0100, 2'd0, 1'b0);
        run_instr(5'b10011, 0, 0, 0, 4'b0000, 2'd2, 1'b0);
        run_instr(5'b10011, 0, 0, 0, 4'b0000, 2'd2, 1'b1);
        run_instr(5'b10011, 0, 0, 0, 4'b0000, 2'd3, 1'b1);
        run_instr(5'b01111, 0, 0, 0, 4'b0000, 2'd0, 1'b0);
        run_instr(5'b10000, 0, 0, 0, 4'b0000, 2'd0, 1'b0);

        // Ready arriving exactly when the counter reaches TIMEOUT succeeds.
        rand_idle = 1'b1;
        run_instr(5'b00000, TIMEOUT, TIMEOUT, 0, 4'b0000, 2'd0, 1'b0);
        run_instr(5'b00001, 0, 0, TIMEOUT, 4'b1111, 2'd0, 1'b0);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            run_instr(ops[$urandom_range(14)], int'($urandom_range(TIMEOUT)),
                      int'($urandom_range(TIMEOUT)), int'($urandom_range(TIMEOUT)),
                      4'($urandom), 2'($urandom), 1'($urandom));
        end

        // Timeout in FETCH_MEM on a LOAD -> FAULT, held until reset.
        do_reset();
        opcode = 5'b00000;
        mem_ready = 1'b1;
        step("ft_fetch", 0, MEM123 | B_IW | B_PCEN);
        step("ft_freg", 1, B_REG1 | B_OP2);
        for (int i = 0; i <= TIMEOUT; i++) begin mem_ready = 1'b0; step("ft_wait", 2, B_MEM4 | B_OP1); end
        for (int i = 0; i < 6; i++) begin mem_ready = 1'(i); step("fault", 5, 18'd0); end
        do_reset();
        mem_ready = 1'b0;
        step("ft_exit", 0, MEM123);

        // Timeout in FETCH_COMM.
        for (int i = 0; i < TIMEOUT; i++) begin mem_ready = 1'b0; step("fc_wait", 0, MEM123); end
        step("fc_fault", 5, 18'd0);

        // Reset in the middle of a store wait.
        do_reset();
        opcode = 5'b00001;
        mem_ready = 1'b1;
        step("st_fetch", 0, MEM123 | B_IW | B_PCEN);
        step("st_freg", 1, B_REG1 | B_REG2 | B_OP1 | B_OP2);
        step("st_fmem", 2, 18'd0);
        flags_in = 4'b1111;
        for (int i = 0; i < 2; i++) begin mem_ready = 1'b0; step("st_wait", 3, B_MEMWE); end
        do_reset();
        mem_ready = 1'b0;
        step("st_abort", 0, MEM123);

        // HALT holds through mem_ready activity until reset.
        do_reset();
        run_instr(5'b11111, 1, 0, 0, 4'b1111, 2'd0, 1'b0);
        for (int i = 0; i < 22; i++) begin mem_ready = 1'($urandom); step("halt", 4, 18'd0); end
        do_reset();
        mem_ready = 1'b0;
        step("halt_exit", 0, MEM123);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
